// File: rtl/uart_frame_sequencer_if.sv
// Handshake bundle between the frame sequencer and its clients: the frame
// request/status lines toward the game logic and the byte launch toward the UART TX core.
interface uart_frame_sequencer_if;
    logic       frame_request;
    logic       frame_busy;
    logic       frame_done;
    logic       tx_ready;
    logic       tx_start;
    logic [7:0] tx_data;

    modport master (
        input  frame_request,
        input  tx_ready,
        output tx_start,
        output tx_data,
        output frame_busy,
        output frame_done
    );

    modport slave (
        output frame_request,
        output tx_ready,
        input  tx_start,
        input  tx_data,
        input  frame_busy,
        input  frame_done
    );
endinterface

// File: rtl/uart_frame_sequencer.sv
// Serializes a snapshot of the game status into one 89-byte checksummed frame,
// issuing one tx_start per byte and pacing itself on the transmitter's ready flag.
module uart_frame_sequencer #(
    parameter logic [7:0] HEADER_BYTE   = 8'hA5,
    parameter bit         AUTO_ON_STATE = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset,
    uart_frame_sequencer_if.master        bus,
    input  logic [2:0]                    current_state,
    input  logic                          game_started,
    input  logic                          game_dificulty,
    input  logic [323:0]                  full_board,
    input  logic [161:0]                  colors,
    input  logic [3:0]                    position_x,
    input  logic [3:0]                    position_y,
    input  logic [1:0]                    errors,
    input  logic [3:0]                    selected_number,
    input  logic                          victory_condition,
    input  logic [6:0]                    score,
    input  logic [10:0]                   time_in_seconds
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_GUARD,
        S_WAIT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic         game_started;
        logic         game_dificulty;
        logic [2:0]   current_state;
        logic [3:0]   position_x;
        logic [3:0]   position_y;
        logic [1:0]   errors;
        logic [3:0]   selected_number;
        logic         victory_condition;
        logic [6:0]   score;
        logic [10:0]  time_in_seconds;
        logic [323:0] full_board;
        logic [161:0] colors;
    } snapshot_t;

    localparam logic [6:0] LAST_INDEX = 7'd88;

    state_t    state_q, state_d;
    snapshot_t snap_q, snap_d;
    logic      pending_q, pending_d;
    logic [6:0] byte_idx_q, byte_idx_d;
    logic [7:0] checksum_q, checksum_d;
    logic [2:0] prev_state_q, prev_state_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       frame_busy_q, frame_busy_d;
    logic       frame_done_q, frame_done_d;

    logic       request;
    logic [6:0] cell_idx;
    logic [7:0] cur_byte;

    assign request = bus.frame_request |
                     (AUTO_ON_STATE && (current_state != prev_state_q));

    // Byte mux over the frozen snapshot; index 88 carries the running checksum.
    always_comb begin
        cell_idx = 7'd0;
        if ((byte_idx_q >= 7'd7) && (byte_idx_q < LAST_INDEX)) begin
            cell_idx = byte_idx_q - 7'd7;
        end
        case (byte_idx_q)
            7'd0:    cur_byte = HEADER_BYTE;
            7'd1:    cur_byte = {snap_q.game_started, snap_q.game_dificulty, 3'b000,
                                 snap_q.current_state};
            7'd2:    cur_byte = {snap_q.position_x, snap_q.position_y};
            7'd3:    cur_byte = {snap_q.victory_condition, snap_q.errors, 1'b0,
                                 snap_q.selected_number};
            7'd4:    cur_byte = {1'b0, snap_q.score};
            7'd5:    cur_byte = {5'b00000, snap_q.time_in_seconds[10:8]};
            7'd6:    cur_byte = snap_q.time_in_seconds[7:0];
            7'd88:   cur_byte = checksum_q;
            default: cur_byte = {snap_q.colors[{cell_idx, 1'b0} +: 2], 2'b00,
                                 snap_q.full_board[{cell_idx, 2'b00} +: 4]};
        endcase
    end

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        byte_idx_d   = byte_idx_q;
        checksum_d   = checksum_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        prev_state_d = current_state;
        pending_d    = pending_q | (request && (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (request || pending_q) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                snap_d.game_started      = game_started;
                snap_d.game_dificulty    = game_dificulty;
                snap_d.current_state     = current_state;
                snap_d.position_x        = position_x;
                snap_d.position_y        = position_y;
                snap_d.errors            = errors;
                snap_d.selected_number   = selected_number;
                snap_d.victory_condition = victory_condition;
                snap_d.score             = score;
                snap_d.time_in_seconds   = time_in_seconds;
                snap_d.full_board        = full_board;
                snap_d.colors            = colors;
                byte_idx_d               = 7'd0;
                checksum_d               = 8'h00;
                // A request landing in this very cycle must survive the clear.
                pending_d                = request;
                state_d                  = S_SEND;
            end
            S_SEND: begin
                if (bus.tx_ready) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = cur_byte;
                    if ((byte_idx_q != 7'd0) && (byte_idx_q != LAST_INDEX)) begin
                        checksum_d = checksum_q ^ cur_byte;
                    end
                    state_d = S_GUARD;
                end
            end
            S_GUARD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.tx_ready) begin
                    if (byte_idx_q == LAST_INDEX) begin
                        state_d = S_DONE;
                    end else begin
                        byte_idx_d = byte_idx_q + 7'd1;
                        state_d    = S_SEND;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        frame_busy_d = (state_d == S_LOAD) || (state_d == S_SEND) ||
                       (state_d == S_GUARD) || (state_d == S_WAIT);
        frame_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            snap_q       <= '0;
            pending_q    <= 1'b0;
            byte_idx_q   <= 7'd0;
            checksum_q   <= 8'h00;
            prev_state_q <= current_state;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            frame_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            pending_q    <= pending_d;
            byte_idx_q   <= byte_idx_d;
            checksum_q   <= checksum_d;
            prev_state_q <= prev_state_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            frame_busy_q <= frame_busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.frame_busy = frame_busy_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: doc/uart_frame_sequencer.md
# uart_frame_sequencer

Sequences the shared UART transmitter so the complete game status goes to the host as one fixed-length, checksummed byte frame. Each frame takes a snapshot of the game-state, board, color, cursor and end-game signals and serializes it byte by byte. It issues one `tx_start` per byte and waits on the transmitter's ready flag between bytes. The block sits between the game FSM/datapath and the UART TX core, and is that core's only client.

## Interface
- `HEADER_BYTE`, 8'hA5, first byte of every frame.
- `AUTO_ON_STATE`, 1, when 1 a change of `current_state` requests a frame.
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `frame_request`  in  1  one-cycle request for a frame.
- `current_state`  in  3  game FSM state.
- `game_started`, `game_dificulty`  in  1 each  game status flags.
- `full_board`  in  324  81 cells × 4 bits; cell i = bits [4i+3:4i].
- `colors`  in  162  81 cells × 2 bits; cell i = bits [2i+1:2i].
- `position_x`, `position_y`  in  4 each  cursor.
- `errors`  in  2.
- `selected_number`  in  4.
- `victory_condition`  in  1.
- `score`  in  7.
- `time_in_seconds`  in  11.
- `tx_ready`  in  1  UART TX idle and able to accept a byte.
- `tx_start`  out  1  one-cycle byte launch.
- `tx_data`  out  8  byte to send; valid while `tx_start` is high, held afterwards.
- `frame_busy`  out  1  high from snapshot until the last byte is accepted.
- `frame_done`  out  1  one-cycle pulse after the last byte.

## Operation
- **Frame length:** 89 bytes, index 0..88.
  - 0: `HEADER_BYTE`
  - 1: {`game_started`, `game_dificulty`, 3'b000, `current_state`}
  - 2: {`position_x`, `position_y`}
  - 3: {`victory_condition`, `errors`, 1'b0, `selected_number`}
  - 4: {1'b0, `score`}
  - 5: {5'b0, `time_in_seconds`[10:8]}
  - 6: `time_in_seconds`[7:0]
  - 7..87: cell i = index−7, byte {colors cell i, 2'b00, board cell i}
  - 88: XOR of bytes 1..87. The header byte is not included in the checksum.
- **Snapshot:** all game inputs are registered in LOAD. Input changes during a frame do not affect that frame.
- **Checksum:** accumulated byte by byte as each byte is launched. It is cleared in LOAD.
- **FSM states:** IDLE, LOAD, SEND, GUARD, WAIT, DONE.
  - IDLE: if a request or pending bit is set → LOAD.
  - LOAD: capture snapshot; byte index ← 0; checksum ← 0; pending ← 0 → SEND.
  - SEND: wait for `tx_ready`=1. When it is 1, drive `tx_start`=1 and `tx_data` = byte[index] for one cycle → GUARD.
  - GUARD: one cycle in which `tx_ready` is ignored, covering transmitter registration latency → WAIT.
  - WAIT: when `tx_ready`=1, go to SEND with index+1, or to DONE if index was 88.
  - DONE: `frame_done`=1 for one cycle → IDLE.
- **Auto-request:** `current_state` is registered each cycle. Any difference from the registered copy while `AUTO_ON_STATE`=1 counts as a request.
- **Pending bit:** a request arriving outside IDLE sets one pending bit. Multiple requests collapse into one, and the pending frame starts from DONE→IDLE on the next cycle. A request in the same cycle that LOAD clears the pending bit keeps it set.
- **Byte counter:** 7 bits. It never exceeds 88.

## Timing
- **Reset values:** state IDLE; `tx_start`=0, `tx_data`=8'h00, `frame_busy`=0, `frame_done`=0; pending=0; index=0; checksum=0; registered `current_state` ← input value, so no spurious auto-request follows reset.
- **Reset mid-frame:** abort immediately, no further `tx_start`, partial frame abandoned, pending cleared.
- **Request latency:** request sampled at edge t → LOAD at t+1 → SEND at t+2. With `tx_ready`=1, the first `tx_start` is high in the cycle after edge t+2.
- **Minimum byte spacing:** 3 cycles (SEND, GUARD, WAIT with ready already 1). Normal spacing is set by UART bit time.
- `tx_start` is never high on two consecutive cycles and never high while `tx_ready`=0.
- `frame_busy` rises in LOAD and falls together with the `frame_done` pulse.
- `tx_data` holds its last value between frames.

## Test plan
- **Empty board, manual request:** zero board and colors, `current_state`=3'b011, score=5, time=300, instant-ready stub → 89 bytes A5,03,…,05,01,2C, 81×00, checksum=03^05^01^2C=2B; one `frame_done`; `tx_start` spacing is 3 cycles.
- **Cell packing:** cell 0 value 9 with color 2'b10, cell 80 value 1 with color 2'b01 → byte 7=89, byte 87=41, checksum correct.
- **Slow transmitter:** `tx_ready` low for 20 cycles after each accept → one `tx_start` per byte, no duplicates, 89 bytes total.
- **Requests during a frame:** 3 requests plus 2 state changes mid-frame → exactly one extra frame afterwards; the first frame's byte 1 reflects the snapshot taken in LOAD.
- **Reset at byte 40:** `tx_start` stays 0 after reset. A fresh request restarts at header A5 with index 0.
- **AUTO_ON_STATE=0:** `current_state` changes alone produce no frame; `frame_request` still works.
